// File: rtl/fft_sample_server.sv
// Frame buffer in front of the 64-point FFT: captures DEPTH samples from the stream,
// then answers the FFT's req/ack/result fetch handshake one sample at a time.
module fft_sample_server #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic [0:DW-1] din,
    input  logic          din_valid,
    input  logic          req,
    input  logic [0:AW-1] addr_in,
    output logic          ready,
    output logic          ack,
    output logic          result,
    output logic [0:DW-1] data,
    output logic          overrun,
    output logic          frame_done
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {FILL, SERVE, ACK, WAITLOW, FETCH, RESULT} state_t;

    state_t        r_state;
    logic [AW:0]   r_wp;
    logic [AW:0]   r_sc;
    logic [0:DW-1] r_mem [DEPTH];
    logic [0:DW-1] r_data;
    logic          r_ready;
    logic          r_ack;
    logic          r_result;
    logic          r_overrun;
    logic          r_frame_done;

    logic          w_wr;
    logic          w_last_wr;
    logic          w_last_sc;

    assign w_wr      = (r_state == FILL) && din_valid;
    assign w_last_wr = (r_wp == (AW+1)'(DEPTH - 1));
    assign w_last_sc = (r_sc == (AW+1)'(DEPTH - 1));

    // Buffer is deliberately not reset; a new frame always overwrites it fully.
    always_ff @(posedge c) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_wp         <= '0;
            r_sc         <= '0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_ack        <= 1'b0;
            r_result     <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (din_valid && (r_state != FILL)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                FILL: begin
                    if (din_valid) begin
                        r_wp <= r_wp + (AW+1)'(1);
                        if (w_last_wr) begin
                            r_wp    <= '0;
                            r_sc    <= '0;
                            r_ready <= 1'b1;
                            r_state <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (req) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= WAITLOW;
                end
                WAITLOW: begin
                    if (!req) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // Strobes are set here so they are registered and line up with the data.
                    r_data       <= r_mem[addr_in];
                    r_result     <= 1'b1;
                    r_frame_done <= w_last_sc;
                    r_state      <= RESULT;
                end
                RESULT: begin
                    r_result     <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_sc         <= r_sc + (AW+1)'(1);
                    if (w_last_sc) begin
                        r_ready <= 1'b0;
                        r_state <= FILL;
                    end else begin
                        r_state <= SERVE;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign ready      = r_ready;
    assign ack        = r_ack;
    assign result     = r_result;
    assign data       = r_data;
    assign overrun    = r_overrun;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_fft_sample_server.sv
// Scoreboard bench for fft_sample_server: fetches push expected samples, a monitor
// pops and compares them whenever the DUT strobes result.
module tb_fft_sample_server;
    logic        c;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;
    logic        req;
    logic [5:0]  addr_in;
    logic        ready;
    logic        ack;
    logic        result;
    logic [15:0] data;
    logic        overrun;
    logic        frame_done;

    int checks = 0;
    int passed = 0;
    int ack_cnt = 0;
    logic [16:0] exp_q[$];

    fft_sample_server #(.DW(16), .AW(6)) dut (
        .c(c), .rst_n(rst_n), .din(din), .din_valid(din_valid), .req(req),
        .addr_in(addr_in), .ready(ready), .ack(ack), .result(result),
        .data(data), .overrun(overrun), .frame_done(frame_done)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge c) begin
        if (rst_n && ack) ack_cnt++;
        if (rst_n && result) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("result_data", 32'(data), 32'(e[15:0]));
                check("frame_done", 32'(frame_done), 32'(e[16]));
            end
        end else if (rst_n && frame_done) begin
            check("frame_done_without_result", 32'd1, 32'd0);
        end
    end

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 64; i++) begin
            din = base + 16'(i);
            din_valid = 1'b1;
            check("ready_during_fill", 32'(ready), 32'd0);
            @(posedge c); #1;
        end
        din_valid = 1'b0;
        check("ready_after_fill", 32'(ready), 32'd1);
    endtask

    task automatic fetch(input logic [5:0] a, input int hold, input logic [15:0] exp, input logic fd);
        int n;
        int acks_before;
        @(posedge c); #1;
        exp_q.push_back({fd, exp});
        acks_before = ack_cnt;
        req = 1'b1;
        addr_in = a;
        @(posedge c); #1;
        check("ack_after_req", 32'(ack), 32'd1);
        for (int k = 1; k < hold; k++) begin
            @(posedge c); #1;
        end
        req = 1'b0;
        n = hold - 1;
        while (result !== 1'b1 && n < 20) begin
            @(posedge c); #1;
            n++;
        end
        check("req_to_result_latency", 32'(n), 32'((hold < 2 ? 2 : hold) + 1));
        @(negedge c);
        check("single_ack", 32'(ack_cnt - acks_before), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; req = 1'b0; addr_in = '0;
        repeat (3) @(posedge c);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        @(posedge c); #1;

        fill(16'h1000);
        check("no_overrun_after_fill", 32'(overrun), 32'd0);

        // Stray write while serving: flagged, dropped, buffer slot 0 untouched.
        din = 16'hDEAD;
        din_valid = 1'b1;
        @(posedge c); #1;
        din_valid = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);

        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = 6'(i);
            fetch(a, (i == 6) ? 6 : 2, 16'h1000 + 16'(i), i == 63);
        end
        check("ready_still_high_in_last_result", 32'(ready), 32'd1);
        @(posedge c); #1;
        check("ready_low_after_frame", 32'(ready), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        fill(16'h2000);
        fetch(6'd3, 2, 16'h2003, 1'b0);
        fetch(6'd3, 3, 16'h2003, 1'b0);
        fetch(6'd62, 2, 16'h203E, 1'b0);

        @(posedge c); #1;
        req = 1'b1;
        addr_in = 6'd10;
        @(posedge c); #1;
        check("ack_before_reset", 32'(ack), 32'd1);
        @(posedge c); #1;
        rst_n = 1'b0;
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        req = 1'b0;
        @(posedge c); #1;
        rst_n = 1'b1;
        @(posedge c); #1;

        fill(16'h3000);
        fetch(6'd63, 2, 16'h303F, 1'b0);
        fetch(6'd0, 4, 16'h3000, 1'b0);

        repeat (3) @(posedge c);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fft_sample_server.md
# fft_sample_server

Sample source that sits in front of the 64-point FFT datapath and answers its `ready`/`req`/`ack`/`result` fetch protocol. Captures a frame of 64 16-bit samples from an upstream stream into a local buffer, then serves one sample per request at the address the FFT presents. After all 64 are served, it re-arms for the next frame.

## Interface
- `DW`, 16, sample width
- `AW`, 6, address width; buffer depth is 2^AW = 64
- `c`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `din`  in  [0:DW-1]  upstream sample
- `din_valid`  in  1  `din` valid this cycle
- `req`  in  1  fetch request from the FFT
- `addr_in`  in  [0:AW-1]  FFT sample address (its `addrOut`)
- `ready`  out  1  frame buffered, requests accepted
- `ack`  out  1  one-cycle request acknowledge
- `result`  out  1  one-cycle strobe, `data` valid
- `data`  out  [0:DW-1]  served sample
- `overrun`  out  1  sticky: `din_valid` seen while not in FILL
- `frame_done`  out  1  one-cycle pulse after 64th sample served

## Operation
- Storage: 64 x DW buffer `mem`; 7-bit write pointer `wp`; 7-bit serve counter `sc`.
- States: FILL, SERVE, ACK, WAITLOW, FETCH, RESULT.
- FILL: on each `din_valid`, `mem[wp[AW-1:0]] <= din` and `wp++`. When the write with `wp == 63` occurs, go to SERVE; `wp <= 0`, `sc <= 0`.
- SERVE: `ready = 1`. If `req == 1`, go to ACK.
- ACK: `ack = 1` for exactly this cycle, then go to WAITLOW.
- WAITLOW: stay until `req == 0`, then go to FETCH. A `req` held high is never re-acknowledged.
- FETCH: `data <= mem[addr_in]`, then go to RESULT.
- RESULT: `result = 1` for one cycle and `sc++`.
  - If `sc == 63` (64th serve): `frame_done = 1`, `ready <= 0`, go to FILL.
  - Otherwise go to SERVE.
- `ready` stays 1 from entry to SERVE through the final RESULT. It is registered and deasserts the cycle after the last RESULT.
- `data` holds its last value between fetches.
- Addresses are not checked against `sc`; out-of-order or repeated addresses are served as given.
- `overrun` sets on `din_valid` in any state other than FILL and clears only on reset. The sample is dropped; `mem` is not written.
- Counters are 7 bits, so there is no aliasing at the 63 to 64 boundary; only the low 6 bits index `mem`.
- The `req`/`result` sequence is strictly serial: at most one fetch outstanding.

## Timing
- Reset (async assert, sync release): state = FILL, `wp = sc = 0`; `ready = ack = result = frame_done = overrun = 0`; `data = 0`. `mem` contents are not reset.
- Reset mid-frame or mid-transaction aborts immediately; the partial frame is discarded.
- Write latency: `din` sampled on the edge where `din_valid = 1`. `ready` is high on the edge after the 64th write.
- Request path, with `req` seen high at edge t:
  - `ack` high during cycle t+1.
  - If `req` drops at t+2 (the FFT clears `req` on `ack`), FETCH is at t+3 and `result`/`data` are valid in cycle t+4.
  - Minimum `req`-to-`result` is 4 cycles; each extra cycle `req` stays high adds 1.
- `addr_in` is sampled in FETCH only, at least 3 cycles after `req` rises, so the FFT's registered `addrOut` has settled.
- `frame_done` is coincident with the final `result`.
- `din_valid` in the same cycle as the transition into FILL is ignored and flags `overrun`. The first accepted write is the cycle after.

## Test plan
- Fill: reset, stream 64 samples `din = 16'h1000 + i` back-to-back. Expect `ready = 0` through write 63 and `ready = 1` on the next edge; no `overrun`.
- Single fetch: `req = 1` for 2 cycles, `addr_in = 5`. Expect `ack` pulse 1 cycle after `req` and `result` 4 cycles after `req` with `data = 16'h1005`.
- Held request: keep `req` high 6 cycles. Expect exactly one `ack`; `result` 2 cycles after `req` falls; no second `ack`.
- Full frame: drive the FFT-style sequence for addresses 0..63. Expect 64 `result` pulses with `data = 16'h1000 + addr`, `frame_done` on the 64th, and `ready` low the next cycle; a new 64-sample stream re-arms.
- Overrun: assert `din_valid` once while in SERVE. Expect `overrun = 1` sticky and `mem` unchanged (fetch that address, expect original data).
- Reset mid-transaction: drop `rst_n` in the cycle after `ack`. Expect `ack`, `result`, and `ready` immediately 0; state is FILL; a fresh 64-sample fill is required before `ready`.
